// File: rtl/multicore_pkg.sv
// Shared constants and types for the multicore result scheduler.
// Holds the default array geometry (core count, result/enable/index widths,
// reset stagger spacing), the out_en value that marks a real result, and the
// sequencer state enum.
package multicore_pkg;

    localparam int N_CORES      = 25;
    localparam int DATA_W       = 28;
    localparam int EN_W         = 4;
    localparam int ID_W         = 5;
    localparam int STAGGER      = 17;

    // Only this exact out_en value counts as a result pulse.
    localparam int OUT_EN_VALID = 1;

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_DONE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/multicore_result_sched_rr_arbiter.sv
// Round-robin request arbiter.
// Searches the request vector starting at index ptr and moving upward modulo N,
// and grants the first asserted request. Purely combinational.
// Ports:
//   en        - arbitration enabled; when low no grant is issued
//   req       - one request bit per requester
//   ptr       - search start index, must be below N
//   gnt       - one-hot grant
//   gnt_idx   - encoded index of the granted requester
//   gnt_valid - a grant was issued this cycle
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int off = 0; off < N; off++) begin
            // ptr < N and off < N, so a single subtraction folds the sum back into range.
            cand = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (en && !gnt_valid && req[cand[IDX_W-1:0]]) begin
                gnt_valid                 = 1'b1;
                gnt_idx                   = cand[IDX_W-1:0];
                gnt[cand[IDX_W-1:0]]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicore_result_sched.sv
// Sequencer and result arbiter for an array of cores sharing one output bus.
// Releases the per-core resets one after another with a fixed spacing, captures
// each core's single-cycle result pulse into its own holding slot, and drains the
// slots round-robin into a registered valid/ready stream tagged with the core index.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   core_io_out   - flattened core results, core i at [i*DATA_W +: DATA_W]
//   core_out_en   - flattened core out_en fields, core i at [i*EN_W +: EN_W]
//   core_rst      - per-core reset, active-high
//   out_data      - granted result (signed)
//   out_core      - index of the core that produced out_data
//   out_valid     - out_data/out_core valid
//   out_ready     - downstream accepts
//   seq_done      - every core has been released from reset
//   overflow      - sticky per-core lost-result flags
//   clear_ovf     - clears overflow
module multicore_result_sched
    import multicore_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES*DATA_W-1:0]   core_io_out,
    input  logic [N_CORES*EN_W-1:0]     core_out_en,
    output logic [N_CORES-1:0]          core_rst,
    output logic signed [DATA_W-1:0]    out_data,
    output logic [ID_W-1:0]             out_core,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        seq_done,
    output logic [N_CORES-1:0]          overflow,
    input  logic                        clear_ovf
);

    localparam int CNT_W = $clog2(STAGGER + 1);

    seq_state_t                  state_q;
    seq_state_t                  state_d;
    logic [CNT_W-1:0]            stagger_cnt;
    logic [ID_W-1:0]             rel_idx;
    logic                        release_now;

    logic [N_CORES-1:0]          fire;
    logic [N_CORES-1:0]          slot_full;
    logic signed [DATA_W-1:0]    slot_data [N_CORES];

    logic                        out_free;
    logic [ID_W-1:0]             rr_ptr;
    logic [N_CORES-1:0]          gnt;
    logic [ID_W-1:0]             gnt_idx;
    logic                        gnt_valid;

    // ---------------- Reset sequencer ----------------

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A release happens whenever the stagger counter has run down to zero;
    // releasing the last core retires the sequencer for good.
    always_comb begin
        state_d     = state_q;
        release_now = 1'b0;
        if (state_q == SEQ_RUN && stagger_cnt == '0) begin
            release_now = 1'b1;
            if (rel_idx == ID_W'(N_CORES - 1)) begin
                state_d = SEQ_DONE;
            end
        end
    end

    // Reloading with STAGGER-1 after a release puts the next release exactly
    // STAGGER edges later; the counter starts at zero so core 0 goes on edge 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst    <= '1;
            stagger_cnt <= '0;
            rel_idx     <= '0;
        end else if (release_now) begin
            core_rst[rel_idx] <= 1'b0;
            stagger_cnt       <= CNT_W'(STAGGER - 1);
            if (rel_idx == ID_W'(N_CORES - 1)) begin
                rel_idx <= '0;
            end else begin
                rel_idx <= rel_idx + 1'b1;
            end
        end else if (state_q == SEQ_RUN) begin
            stagger_cnt <= stagger_cnt - 1'b1;
        end
    end

    assign seq_done = (state_q == SEQ_DONE);

    // ---------------- Capture into holding slots ----------------

    always_comb begin
        fire = '0;
        for (int i = 0; i < N_CORES; i++) begin
            fire[i] = (core_out_en[i*EN_W +: EN_W] == EN_W'(OUT_EN_VALID)) && !core_rst[i];
        end
    end

    // A slot being granted this cycle is free to take a new result at the same
    // edge; only a fire into a full, ungranted slot loses data. A fresh overflow
    // takes priority over clear_ovf so a loss in the clearing cycle is not hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            overflow  <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (fire[i] && (!slot_full[i] || gnt[i])) begin
                    slot_data[i] <= core_io_out[i*DATA_W +: DATA_W];
                    slot_full[i] <= 1'b1;
                end else if (gnt[i]) begin
                    slot_full[i] <= 1'b0;
                end

                if (fire[i] && slot_full[i] && !gnt[i]) begin
                    overflow[i] <= 1'b1;
                end else if (clear_ovf) begin
                    overflow[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- Arbitration and output register ----------------

    assign out_free = !out_valid || out_ready;

    rr_arbiter #(
        .N     (N_CORES),
        .IDX_W (ID_W)
    ) u_arb (
        .en        (out_free),
        .req       (slot_full),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // The output only moves when it is free, so a stalled beat stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_core  <= '0;
            rr_ptr    <= '0;
        end else if (out_free) begin
            if (gnt_valid) begin
                out_valid <= 1'b1;
                out_data  <= slot_data[gnt_idx];
                out_core  <= gnt_idx;
                if (gnt_idx == ID_W'(N_CORES - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= gnt_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
